// File: rtl/tl_grant_pkg.sv
// Shared definitions for the client-side TileLink Grant path.
// Holds the Grant type encodings, block geometry, id widths, the FSM state
// type and the two classification helpers used to decide whether a Grant
// carries multibeat data and whether it must be acknowledged with a Finish.
package tl_grant_pkg;

  localparam int DATA_BEATS  = 8;
  localparam int BEAT_W      = $clog2(DATA_BEATS);
  localparam int CLIENT_ID_W = 1;
  localparam int MGR_ID_W    = 2;
  localparam int DATA_W      = 64;
  localparam int G_TYPE_W    = 4;

  // Built-in Grant types (is_builtin_type = 1)
  localparam logic [G_TYPE_W-1:0] G_VOID_ACK           = 4'd0;
  localparam logic [G_TYPE_W-1:0] G_PREFETCH_ACK       = 4'd1;
  localparam logic [G_TYPE_W-1:0] G_PUT_ACK            = 4'd2;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BEAT_ACK  = 4'd3;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BLOCK_ACK = 4'd4;

  // Coherence-policy Grant types (is_builtin_type = 0)
  localparam logic [G_TYPE_W-1:0] G_GRANT_SHARED_DATA  = 4'd0;
  localparam logic [G_TYPE_W-1:0] G_GRANT_EXCL_DATA    = 4'd1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_BLOCK = 1'b1
  } gfu_state_e;

  // A Grant spans DATA_BEATS beats when it returns a whole cache block.
  function automatic logic has_multibeat_data(input logic                builtin,
                                              input logic [G_TYPE_W-1:0] g_type);
    if (builtin) return (g_type == G_GET_DATA_BLOCK_ACK);
    return (g_type == G_GRANT_SHARED_DATA) || (g_type == G_GRANT_EXCL_DATA);
  endfunction

  // Every Grant except the built-in voidAck must be answered with a Finish.
  function automatic logic requires_finish(input logic                builtin,
                                           input logic [G_TYPE_W-1:0] g_type);
    return !(builtin && (g_type == G_VOID_ACK));
  endfunction

endpackage

// File: rtl/finish_reg.sv
// One-entry holding register for the outgoing Finish message.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load_i              capture src/dst/mgr and raise valid
//   src_i, dst_i, mgr_i Finish header fields to capture
//   ready_i             downstream accepts the Finish when valid_o & ready_i
//   valid_o             a Finish is held
//   src_o, dst_o, mgr_o held Finish fields
// A load in the same cycle as a release wins: valid stays high with the new
// contents, so the slot is never empty for a cycle between back-to-back Finishes.
module finish_reg
  import tl_grant_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [MGR_ID_W-1:0] src_i,
  input  logic [MGR_ID_W-1:0] dst_i,
  input  logic [MGR_ID_W-1:0] mgr_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [MGR_ID_W-1:0] src_o,
  output logic [MGR_ID_W-1:0] dst_o,
  output logic [MGR_ID_W-1:0] mgr_o
);

  logic                valid_q, valid_d;
  logic [MGR_ID_W-1:0] src_q, src_d;
  logic [MGR_ID_W-1:0] dst_q, dst_d;
  logic [MGR_ID_W-1:0] mgr_q, mgr_d;

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    dst_d   = dst_q;
    mgr_d   = mgr_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      src_d   = src_i;
      dst_d   = dst_i;
      mgr_d   = mgr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      mgr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      mgr_q   <= mgr_d;
    end
  end

  assign valid_o = valid_q;
  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign mgr_o   = mgr_q;

endmodule

// File: rtl/grant_finish_unit.sv
// Grant finish unit: consumes Grant beats from the Grant queue, forwards the
// payload to the client with zero latency, tracks multibeat blocks and
// issues one Finish toward the manager on the last beat of every Grant that
// needs acknowledgement.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_*                       Grant beat from the queue (valid/ready)
//   out_*                      Grant payload to the client (valid/ready)
//   fin_*                      Finish message to the manager (valid/ready)
//   beat_err                   sticky: a block beat arrived with an unexpected addr_beat
//   busy                       mid-block or a Finish is still pending
// Handshakes: a transfer happens on a cycle where valid & ready are both high.
// valid never depends on the same interface's ready; in_ready/out_valid are
// combinational and only differ from out_ready/in_valid when the beat would
// load a Finish while the Finish slot is occupied and not draining.
module grant_finish_unit
  import tl_grant_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MGR_ID_W-1:0]    in_header_src,
  input  logic [MGR_ID_W-1:0]    in_header_dst,
  input  logic [BEAT_W-1:0]      in_addr_beat,
  input  logic [CLIENT_ID_W-1:0] in_client_xact_id,
  input  logic [MGR_ID_W-1:0]    in_manager_xact_id,
  input  logic                   in_is_builtin_type,
  input  logic [G_TYPE_W-1:0]    in_g_type,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BEAT_W-1:0]      out_addr_beat,
  output logic [CLIENT_ID_W-1:0] out_client_xact_id,
  output logic [MGR_ID_W-1:0]    out_manager_xact_id,
  output logic                   out_is_builtin_type,
  output logic [G_TYPE_W-1:0]    out_g_type,
  output logic [DATA_W-1:0]      out_data,
  output logic                   fin_valid,
  input  logic                   fin_ready,
  output logic [MGR_ID_W-1:0]    fin_header_src,
  output logic [MGR_ID_W-1:0]    fin_header_dst,
  output logic [MGR_ID_W-1:0]    fin_manager_xact_id,
  output logic                   beat_err,
  output logic                   busy
);

  gfu_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              beat_err_q, beat_err_d;

  logic multibeat, needs_fin, is_last, fin_slot_ok, pass_ok, fire, fin_load;

  // Payload is a straight copy of the dequeued beat.
  assign out_addr_beat       = in_addr_beat;
  assign out_client_xact_id  = in_client_xact_id;
  assign out_manager_xact_id = in_manager_xact_id;
  assign out_is_builtin_type = in_is_builtin_type;
  assign out_g_type          = in_g_type;
  assign out_data            = in_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

  // Output / handshake logic
  always_comb begin
    multibeat   = has_multibeat_data(in_is_builtin_type, in_g_type);
    needs_fin   = requires_finish(in_is_builtin_type, in_g_type);
    is_last     = !multibeat || (beat_cnt_q == LAST_BEAT);
    fin_slot_ok = !fin_valid || fin_ready;
    // Only a beat that would load a Finish has to wait for the slot.
    pass_ok     = !(needs_fin && is_last) || fin_slot_ok;
    in_ready    = out_ready && pass_ok;
    out_valid   = in_valid && pass_ok;
    fire        = in_valid && in_ready;
    fin_load    = fire && is_last && needs_fin;
    busy        = (state_q == ST_IN_BLOCK) || fin_valid;
    beat_err    = beat_err_q;
  end

  // Next-state logic; the counter follows accepted beats, not addr_beat.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beat_err_d = beat_err_q;
    if (fire) begin
      if (multibeat && (in_addr_beat != beat_cnt_q)) beat_err_d = 1'b1;
      if (is_last) begin
        beat_cnt_d = '0;
        state_d    = ST_IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        state_d    = ST_IN_BLOCK;
      end
    end
  end

  // Finish goes back to the sender of the Grant, so src and dst swap.
  finish_reg u_finish_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (fin_load),
    .src_i   (in_header_dst),
    .dst_i   (in_header_src),
    .mgr_i   (in_manager_xact_id),
    .ready_i (fin_ready),
    .valid_o (fin_valid),
    .src_o   (fin_header_src),
    .dst_o   (fin_header_dst),
    .mgr_o   (fin_manager_xact_id)
  );

endmodule
